// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory stalls, load-use bubbles,
// branch flushes, operand forwarding and a saturating stall counter.
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  dec_srcA,
    input  logic [2:0]  dec_srcB,
    input  logic        dec_useA,
    input  logic        dec_useB,
    input  logic [2:0]  alu_dest,
    input  logic        alu_we,
    input  logic [1:0]  alu_ldSt,
    input  logic [2:0]  mem_dest,
    input  logic        mem_we,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        branch_taken,
    input  logic        stall_clr,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_alu,
    output logic        enable_mem,
    output logic        insert_bubble,
    output logic        flush_decode,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_count
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_FLUSH    = 2'd2;

    localparam logic [1:0] LDST_LOAD = 2'b01;

    logic [1:0]  state_q, state_d;
    logic [15:0] stall_count_q, stall_count_d;

    logic mstall;
    logic lduse;
    logic alu_is_load;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    assign mstall      = mem_req & ~mem_ready;
    assign alu_is_load = (alu_ldSt == LDST_LOAD);
    assign lduse       = alu_is_load & alu_we &
                         ((dec_useA & (dec_srcA == alu_dest)) |
                          (dec_useB & (dec_srcB == alu_dest)));

    always_comb begin
        state_d       = state_q;
        enable_fetch  = 1'b1;
        enable_decode = 1'b1;
        enable_alu    = 1'b1;
        enable_mem    = 1'b1;
        insert_bubble = 1'b0;
        flush_decode  = 1'b0;
        case (state_q)
            S_RUN: begin
                if (mstall) begin
                    enable_fetch  = 1'b0;
                    enable_decode = 1'b0;
                    enable_alu    = 1'b0;
                    enable_mem    = 1'b0;
                    state_d       = S_MEM_WAIT;
                end else if (branch_taken) begin
                    insert_bubble = 1'b1;
                    flush_decode  = 1'b1;
                    state_d       = S_FLUSH;
                end else if (lduse) begin
                    enable_fetch  = 1'b0;
                    enable_decode = 1'b0;
                    insert_bubble = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                // The frozen ALU register keeps any pending branch for RUN.
                if (!mem_ready) begin
                    enable_fetch  = 1'b0;
                    enable_decode = 1'b0;
                    enable_alu    = 1'b0;
                    enable_mem    = 1'b0;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FLUSH: begin
                if (mstall) begin
                    enable_fetch  = 1'b0;
                    enable_decode = 1'b0;
                    enable_alu    = 1'b0;
                    enable_mem    = 1'b0;
                end else begin
                    insert_bubble = 1'b1;
                    flush_decode  = 1'b1;
                    state_d       = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        fwd_a_raw = 2'b00;
        if (dec_useA & alu_we & ~alu_is_load & (alu_dest == dec_srcA))
            fwd_a_raw = 2'b01;
        else if (dec_useA & mem_we & (mem_dest == dec_srcA))
            fwd_a_raw = 2'b10;
    end

    always_comb begin
        fwd_b_raw = 2'b00;
        if (dec_useB & alu_we & ~alu_is_load & (alu_dest == dec_srcB))
            fwd_b_raw = 2'b01;
        else if (dec_useB & mem_we & (mem_dest == dec_srcB))
            fwd_b_raw = 2'b10;
    end

    assign fwd_a = insert_bubble ? 2'b00 : fwd_a_raw;
    assign fwd_b = insert_bubble ? 2'b00 : fwd_b_raw;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_clr)
            stall_count_d = 16'h0000;
        else if (!enable_decode && (stall_count_q != 16'hFFFF))
            stall_count_d = stall_count_q + 16'h0001;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_RUN;
            stall_count_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  dec_srcA, dec_srcB;
    logic        dec_useA, dec_useB;
    logic [2:0]  alu_dest;
    logic        alu_we;
    logic [1:0]  alu_ldSt;
    logic [2:0]  mem_dest;
    logic        mem_we, mem_req, mem_ready;
    logic        branch_taken, stall_clr;
    logic        enable_fetch, enable_decode, enable_alu, enable_mem;
    logic        insert_bubble, flush_decode;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .dec_srcA(dec_srcA), .dec_srcB(dec_srcB),
        .dec_useA(dec_useA), .dec_useB(dec_useB),
        .alu_dest(alu_dest), .alu_we(alu_we), .alu_ldSt(alu_ldSt),
        .mem_dest(mem_dest), .mem_we(mem_we),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .stall_clr(stall_clr),
        .enable_fetch(enable_fetch), .enable_decode(enable_decode),
        .enable_alu(enable_alu), .enable_mem(enable_mem),
        .insert_bubble(insert_bubble), .flush_decode(flush_decode),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
    );

    function automatic logic [3:0] ens();
        return {enable_fetch, enable_decode, enable_alu, enable_mem};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // enables, bubble, flush, fwd_a, fwd_b
    task automatic chk_out(input string tag, input logic [3:0] e,
                           input logic b, input logic f,
                           input logic [1:0] fa, input logic [1:0] fb);
        chk({tag, ".en"}, {12'h0, ens()}, {12'h0, e});
        chk({tag, ".bub"}, {15'h0, insert_bubble}, {15'h0, b});
        chk({tag, ".fl"}, {15'h0, flush_decode}, {15'h0, f});
        chk({tag, ".fa"}, {14'h0, fwd_a}, {14'h0, fa});
        chk({tag, ".fb"}, {14'h0, fwd_b}, {14'h0, fb});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_srcA = 3'd0; dec_srcB = 3'd0;
        dec_useA = 1'b0; dec_useB = 1'b0;
        alu_dest = 3'd0; alu_we = 1'b0; alu_ldSt = 2'b00;
        mem_dest = 3'd0; mem_we = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
        branch_taken = 1'b0; stall_clr = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        #12;
        chk("rst.cnt", stall_count, 16'h0000);
        reset = 1'b1;
        tick();
        chk_out("rst", 4'b1111, 1'b0, 1'b0, 2'b00, 2'b00);
        chk("rst.cnt2", stall_count, 16'h0000);

        // load-use on A: one bubble, then forward from memory stage
        alu_ldSt = 2'b01; alu_we = 1'b1; alu_dest = 3'd3;
        dec_srcA = 3'd3; dec_useA = 1'b1;
        #1;
        chk_out("lduse", 4'b0011, 1'b1, 1'b0, 2'b00, 2'b00);
        tick();
        chk("lduse.cnt", stall_count, 16'h0001);
        alu_ldSt = 2'b00; alu_we = 1'b0; alu_dest = 3'd0;
        mem_we = 1'b1; mem_dest = 3'd3;
        #1;
        chk_out("lduse2", 4'b1111, 1'b0, 1'b0, 2'b10, 2'b00);
        tick();
        chk("lduse2.cnt", stall_count, 16'h0001);

        // ALU and memory both write r5: ALU wins
        idle();
        alu_we = 1'b1; alu_dest = 3'd5;
        mem_we = 1'b1; mem_dest = 3'd5;
        dec_srcB = 3'd5; dec_useB = 1'b1;
        #1;
        chk_out("fwdpri", 4'b1111, 1'b0, 1'b0, 2'b00, 2'b01);
        dec_useB = 1'b0;
        #1;
        chk_out("nouse", 4'b1111, 1'b0, 1'b0, 2'b00, 2'b00);
        tick();

        // memory stall: RUN + 3 MEM_WAIT cycles with enables low
        idle();
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        chk("clr.cnt", stall_count, 16'h0000);
        mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        chk_out("ms.run", 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00);
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) branch_taken = 1'b1;
            #1;
            chk_out("ms.wait", 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk_out("ms.rdy", 4'b1111, 1'b0, 1'b0, 2'b00, 2'b00);
        tick();
        chk("ms.cnt", stall_count, 16'h0004);

        // held branch acted on in RUN, then FLUSH
        mem_req = 1'b0; mem_ready = 1'b0;
        #1;
        chk_out("br1", 4'b1111, 1'b1, 1'b1, 2'b00, 2'b00);
        tick();
        branch_taken = 1'b0;
        alu_we = 1'b1; alu_dest = 3'd5;
        dec_srcA = 3'd5; dec_useA = 1'b1;
        #1;
        chk_out("br2", 4'b1111, 1'b1, 1'b1, 2'b00, 2'b00);
        tick();
        #1;
        chk_out("br.done", 4'b1111, 1'b0, 1'b0, 2'b01, 2'b00);
        idle();

        // branch with memory stall during FLUSH
        branch_taken = 1'b1;
        #1;
        chk_out("bs1", 4'b1111, 1'b1, 1'b1, 2'b00, 2'b00);
        tick();
        branch_taken = 1'b0;
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk_out("bs.stall", 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk_out("bs.rel", 4'b1111, 1'b1, 1'b1, 2'b00, 2'b00);
        tick();
        idle();
        #1;
        chk_out("bs.done", 4'b1111, 1'b0, 1'b0, 2'b00, 2'b00);

        // saturation of stall_count
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (65534) tick();
        chk("sat.fffe", stall_count, 16'hFFFE);
        repeat (3) tick();
        chk("sat.ffff", stall_count, 16'hFFFF);
        stall_clr = 1'b1;
        tick();
        chk("sat.clr", stall_count, 16'h0000);
        stall_clr = 1'b0;
        mem_ready = 1'b1;
        tick();
        idle();
        tick();

        // reset during MEM_WAIT
        mem_req = 1'b1; mem_ready = 1'b0;
        tick();
        tick();
        chk("rw.cnt", stall_count, 16'h0002);
        reset = 1'b0;
        #1;
        chk("rw.cnt0", stall_count, 16'h0000);
        mem_req = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk_out("rw.rel", 4'b1111, 1'b0, 1'b0, 2'b00, 2'b00);
        tick();
        chk("rw.cnt1", stall_count, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
